reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- 32-entry x DATA_W register file for the single-issue CPU datapath; sits directly downstream of the 5-bit write-address select mux (rd / rt / link-register choice), which drives wr_addr.
- Two combinational read ports with same-cycle write bypass.
- Busy-bit scoreboard marks destinations of in-flight instructions and raises stall for RAW/WAW hazards at issue.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wr_en  input  1  write-back enable.
- wr_addr  input  ADDR_W  write-back address, from the write-address select mux.
- wr_data  input  DATA_W  write-back data.
- issue_req  input  1  decode requests issue of an instruction.
- issue_wr  input  1  issuing instruction writes a destination.
- issue_addr  input  ADDR_W  destination to reserve.
- stall  output  1  issue refused this cycle.
- rs_busy  output  1  rs_addr has a pending, un-bypassed write.
- rt_busy  output  1  rt_addr has a pending, un-bypassed write.
- pending_cnt  output  ADDR_W+1  number of set busy bits.

Behaviour:
- Reset: the interface is one clock (clk); reset rst is asynchronous and active-high.
  - rst asserted clears all registers to 0, all busy bits to 0, and pending_cnt to 0 immediately, without waiting for clk.
  - While rst is high: stall=0, rs_busy=0, rt_busy=0, and rs_data/rt_data read 0.
  - Reset asserted mid-operation discards all pending reservations.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked busy; issue_addr=0 reserves nothing.
- Write: at posedge clk, if wr_en and wr_addr!=0, regs[wr_addr] <= wr_data.
- Read: combinational, 0-cycle latency.
  - If wr_en and wr_addr==rs_addr and rs_addr!=0, rs_data=wr_data (bypass); otherwise rs_data=regs[rs_addr].
  - The same rule applies to rt.
- Busy flags:
  - hit_rs = wr_en and wr_addr==rs_addr.
  - rs_busy = busy[rs_addr] and not hit_rs.
  - rt_busy is defined the same way on rt_addr.
  - dest_busy = issue_wr and busy[issue_addr] and not (wr_en and wr_addr==issue_addr).
- Stall:
  - stall = issue_req and (rs_busy or rt_busy or dest_busy).
  - The pipeline decides whether rs/rt are actually used by gating issue_req.
  - accept = issue_req and not stall and issue_wr and issue_addr!=0.
- Scoreboard update at posedge clk:
  - clear busy[wr_addr] if wr_en.
  - set busy[issue_addr] if accept.
  - If both target the same address in the same cycle, set wins: the new producer owns the register.
- pending_cnt is registered and updated at the same edge as the busy bits.
  - Each cycle it changes by +1 (accept on a non-busy register), -1 (clear of a busy register with no same-address set), or 0.
  - Range 0..31; it never wraps.
- A write to a non-busy register updates data and leaves busy and pending_cnt unchanged.
- A write with wr_en to wr_addr=0 is a no-op in every respect.

Test Plan:
- Assert rst asynchronously mid-cycle after writing r5=0xDEADBEEF and reserving r7 -> rs_addr=5 reads 0 before the next edge; busy bits clear, pending_cnt=0, stall=0.
- wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; then read r0 -> rs_data=0 in both the bypass cycle and the following cycle.
- Write r3=0x12345678 with rs_addr=3 in the same cycle -> rs_data=0x12345678 that cycle (bypass) and on subsequent cycles from storage.
- Issue with issue_addr=9 accepted (pending_cnt 0->1); next cycle issue_req with rt_addr=9 -> stall=1, rt_busy=1.
  - Then wr_en to r9 with wr_data=0x55 -> stall=0 and rt_data=0x55 in that same cycle; busy[9] clears at the edge, pending_cnt=0.
- Same cycle: wr_en to r4 (busy) and an accepted issue to r4 -> busy[4] stays 1 and pending_cnt is unchanged.
- Reserve r1..r31 sequentially -> pending_cnt=31; an issue to r12 with issue_wr=1 -> stall=1 (WAW); all pending_cnt transitions match the busy-bit population count.

Source files
------------

// File: rtl/reg_file_if.sv
// reg_file_if: read, write-back and issue signals between decode and the register file scoreboard
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_req;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_addr;
    logic              stall;
    logic              rs_busy;
    logic              rt_busy;
    logic [ADDR_W:0]   pending_cnt;

    modport master (
        output rs_addr, rt_addr, wr_en, wr_addr, wr_data, issue_req, issue_wr, issue_addr,
        input  rs_data, rt_data, stall, rs_busy, rt_busy, pending_cnt
    );
    modport slave (
        input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, issue_req, issue_wr, issue_addr,
        output rs_data, rt_data, stall, rs_busy, rt_busy, pending_cnt
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 2-read/1-write register file with write bypass and a busy-bit hazard scoreboard
module reg_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic       clk,
    input logic       rst,
    reg_file_if.slave bus
);
    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [N];
    logic [N-1:0]      busy;
    logic [N-1:0]      busy_nxt;
    logic              hit_rs;
    logic              hit_rt;
    logic              hit_dst;
    logic              dest_busy;
    logic              accept;
    logic              inc;
    logic              dec;

    always_comb begin
        hit_rs      = bus.wr_en && bus.wr_addr == bus.rs_addr;
        hit_rt      = bus.wr_en && bus.wr_addr == bus.rt_addr;
        hit_dst     = bus.wr_en && bus.wr_addr == bus.issue_addr;
        bus.rs_data = (rst || bus.rs_addr == '0) ? '0 : hit_rs ? bus.wr_data : regs[bus.rs_addr];
        bus.rt_data = (rst || bus.rt_addr == '0) ? '0 : hit_rt ? bus.wr_data : regs[bus.rt_addr];
        bus.rs_busy = busy[bus.rs_addr] && !hit_rs;
        bus.rt_busy = busy[bus.rt_addr] && !hit_rt;
        dest_busy   = bus.issue_wr && busy[bus.issue_addr] && !hit_dst;
        bus.stall   = bus.issue_req && (bus.rs_busy || bus.rt_busy || dest_busy);
        accept      = bus.issue_req && !bus.stall && bus.issue_wr && bus.issue_addr != '0;
        // a same-address write-back and accept hands the register to the new producer
        inc         = accept && !busy[bus.issue_addr];
        dec         = bus.wr_en && busy[bus.wr_addr] && !(accept && bus.issue_addr == bus.wr_addr);
        busy_nxt    = busy;
        if (bus.wr_en) busy_nxt[bus.wr_addr] = 1'b0;
        if (accept) busy_nxt[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            busy            <= '0;
            bus.pending_cnt <= '0;
        end else begin
            if (bus.wr_en && bus.wr_addr != '0) regs[bus.wr_addr] <= bus.wr_data;
            busy            <= busy_nxt;
            bus.pending_cnt <= bus.pending_cnt + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
        end
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed and random stimulus against an array-based register/busy model
module tb_reg_file_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_if rf();
    reg_file_scoreboard dut (.clk(clk), .rst(rst), .bus(rf.slave));

    logic [31:0] m_regs [32];
    logic        m_busy [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popcount();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ir, input logic iw, input logic [4:0] ia);
        rf.rs_addr = ra; rf.rt_addr = rb; rf.wr_en = we; rf.wr_addr = wa; rf.wr_data = wd;
        rf.issue_req = ir; rf.issue_wr = iw; rf.issue_addr = ia;
    endtask

    task automatic cycle(input logic [4:0] ra, input logic [4:0] rb, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ir, input logic iw, input logic [4:0] ia);
        logic hs, ht, hd, rsb, rtb, db, stl, acc;
        @(negedge clk);
        drive(ra, rb, we, wa, wd, ir, iw, ia);
        #1;
        hs  = we && wa == ra;
        ht  = we && wa == rb;
        hd  = we && wa == ia;
        rsb = m_busy[ra] && !hs;
        rtb = m_busy[rb] && !ht;
        db  = iw && m_busy[ia] && !hd;
        stl = ir && (rsb || rtb || db);
        acc = ir && !stl && iw && ia != 0;
        check("rs_data", rf.rs_data, (hs && ra != 0) ? wd : m_regs[ra]);
        check("rt_data", rf.rt_data, (ht && rb != 0) ? wd : m_regs[rb]);
        check("rs_busy", rf.rs_busy, rsb);
        check("rt_busy", rf.rt_busy, rtb);
        check("stall", rf.stall, stl);
        @(posedge clk);
        if (we && wa != 0) m_regs[wa] = wd;
        if (we) m_busy[wa] = 1'b0;
        if (acc) m_busy[ia] = 1'b1;
        #1;
        check("pending_cnt", rf.pending_cnt, popcount());
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(1) == 1) ? 5'($urandom_range(3)) : 5'($urandom_range(31));
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("reset_cnt", rf.pending_cnt, 0);
        check("reset_stall", rf.stall, 0);
        @(negedge clk);
        rst = 1'b0;

        cycle(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("r0_after", rf.rs_data, 0);

        cycle(3, 0, 1, 3, 32'h1234_5678, 0, 0, 0);
        cycle(3, 0, 0, 0, 0, 0, 0, 0);
        check("r3_stored", rf.rs_data, 32'h1234_5678);

        cycle(0, 0, 0, 0, 0, 1, 1, 9);
        check("cnt_r9", rf.pending_cnt, 1);
        cycle(0, 9, 0, 0, 0, 1, 0, 0);
        check("raw_stall", rf.stall, 1);
        check("raw_rt_busy", rf.rt_busy, 1);
        cycle(0, 9, 1, 9, 32'h55, 1, 0, 0);
        check("cnt_r9_clear", rf.pending_cnt, 0);

        cycle(0, 0, 0, 0, 0, 1, 1, 4);
        cycle(0, 0, 1, 4, 32'hAA, 1, 1, 4);
        check("set_wins_cnt", rf.pending_cnt, 1);
        cycle(4, 0, 0, 0, 0, 0, 0, 0);
        check("set_wins_busy", rf.rs_busy, 1);
        cycle(0, 0, 1, 4, 32'h0, 0, 0, 0);

        for (int a = 1; a < 32; a++) cycle(0, 0, 0, 0, 0, 1, 1, 5'(a));
        check("cnt_full", rf.pending_cnt, 31);
        cycle(0, 0, 0, 0, 0, 1, 1, 12);
        check("waw_stall", rf.stall, 1);
        check("cnt_hold", rf.pending_cnt, 31);
        for (int a = 1; a < 32; a++) cycle(0, 0, 1, 5'(a), $urandom, 0, 0, 0);
        check("cnt_empty", rf.pending_cnt, 0);

        for (int n = 0; n < 400; n++)
            cycle(pick(), pick(), 1'($urandom_range(1)), pick(), $urandom,
                  1'($urandom_range(9) < 7), 1'($urandom_range(3) != 0), pick());

        cycle(0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1, 7);
        @(negedge clk);
        drive(5, 7, 1, 5, 32'h1111_1111, 1, 1, 7);
        #1;
        check("pre_rst_rs", rf.rs_data, 32'h1111_1111);
        #1 rst = 1'b1;
        #1;
        check("rst_rs_data", rf.rs_data, 0);
        check("rst_rt_data", rf.rt_data, 0);
        check("rst_stall", rf.stall, 0);
        check("rst_rs_busy", rf.rs_busy, 0);
        check("rst_rt_busy", rf.rt_busy, 0);
        check("rst_cnt", rf.pending_cnt, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(5, 7, 0, 0, 0, 1, 1, 7);
        check("post_rst_cnt", rf.pending_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
